// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network datapath.
// Sequencer state encoding and the signed synapse weight type live here.
package snn_pkg;

    localparam int DEF_NR_WIDTH     = 56;
    localparam int DEF_NR_I_WIDTH   = 16;
    localparam int DEF_SR_SYN_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_RD,
        ST_ROW_LATCH,
        ST_N_RD,
        ST_N_WR,
        ST_DONE
    } seq_state_t;

    typedef logic signed [DEF_SR_SYN_WIDTH-1:0] syn_weight_t;

endpackage

// File: rtl/neuron_accumulator.sv
// Adds a sign-extended synapse weight into the current field of a packed
// neuron state word; the remaining state bits pass through untouched.
module neuron_accumulator
    import snn_pkg::*;
#(
    parameter int NR_WIDTH     = DEF_NR_WIDTH,
    parameter int NR_I_WIDTH   = DEF_NR_I_WIDTH,
    parameter int SR_SYN_WIDTH = DEF_SR_SYN_WIDTH
) (
    input  logic [NR_WIDTH-1:0]            state_in,
    input  logic signed [SR_SYN_WIDTH-1:0] weight,
    output logic [NR_WIDTH-1:0]            state_out
);

    logic [NR_I_WIDTH-1:0] w_ext;
    logic [NR_I_WIDTH-1:0] i_sum;

    // Wrapping add: the current field is modulo 2^NR_I_WIDTH, no saturation.
    always_comb begin
        w_ext     = {{(NR_I_WIDTH-SR_SYN_WIDTH){weight[SR_SYN_WIDTH-1]}}, weight};
        i_sum     = state_in[NR_I_WIDTH-1:0] + w_ext;
        state_out = {state_in[NR_WIDTH-1:NR_I_WIDTH], i_sum};
    end

endmodule

// File: rtl/synapse_event_sequencer.sv
// Takes one presynaptic spike at a time, fetches its synapse row and walks the
// postsynaptic targets with a serialized read-accumulate-write per neuron.
module synapse_event_sequencer
    import snn_pkg::*;
#(
    parameter int N_PRE        = 256,
    parameter int N_POST       = 16,
    parameter int NR_WIDTH     = DEF_NR_WIDTH,
    parameter int NR_I_WIDTH   = DEF_NR_I_WIDTH,
    parameter int SR_SYN_WIDTH = DEF_SR_SYN_WIDTH,
    parameter int SKIP_ZERO    = 1,
    localparam int PRE_W       = $clog2(N_PRE),
    localparam int POST_W      = $clog2(N_POST)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           spike_valid,
    output logic                           spike_ready,
    input  logic [PRE_W-1:0]               spike_idx,
    output logic                           syn_rd_en,
    output logic [PRE_W-1:0]               syn_rd_addr,
    input  logic [N_POST*SR_SYN_WIDTH-1:0] syn_rd_data,
    output logic                           nr_rd_en,
    output logic [POST_W-1:0]              nr_rd_addr,
    input  logic [NR_WIDTH-1:0]            nr_rd_data,
    output logic                           nr_wr_en,
    output logic [POST_W-1:0]              nr_wr_addr,
    output logic [NR_WIDTH-1:0]            nr_wr_data,
    output logic                           done,
    output logic [15:0]                    event_cnt
);

    seq_state_t                     state_q, state_d;
    logic [PRE_W-1:0]               idx_q, idx_d;
    logic [N_POST*SR_SYN_WIDTH-1:0] row_q, row_d;
    logic [POST_W-1:0]              j_q, j_d;
    logic [15:0]                    evt_q, evt_d;

    logic spike_ready_q, spike_ready_d;
    logic syn_rd_en_q, syn_rd_en_d;
    logic nr_rd_en_q, nr_rd_en_d;
    logic nr_wr_en_q, nr_wr_en_d;
    logic done_q, done_d;

    logic signed [SR_SYN_WIDTH-1:0] w_cur;
    logic signed [SR_SYN_WIDTH-1:0] w_next;
    logic                           last_j;
    logic                           skip_cur;

    assign w_cur    = row_q[j_q*SR_SYN_WIDTH +: SR_SYN_WIDTH];
    assign last_j   = (j_q == POST_W'(N_POST-1));
    assign skip_cur = (SKIP_ZERO != 0) && (w_cur == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        j_d     = j_q;
        evt_d   = evt_q;
        w_next  = '0;

        case (state_q)
            ST_IDLE: begin
                if (spike_valid) begin
                    idx_d   = spike_idx;
                    state_d = ST_ROW_RD;
                end
            end
            ST_ROW_RD: state_d = ST_ROW_LATCH;
            ST_ROW_LATCH: begin
                row_d   = syn_rd_data;
                j_d     = '0;
                state_d = ST_N_RD;
            end
            ST_N_RD: begin
                if (skip_cur) begin
                    if (last_j) state_d = ST_DONE;
                    else        j_d     = j_q + POST_W'(1);
                end else begin
                    state_d = ST_N_WR;
                end
            end
            ST_N_WR: begin
                if (last_j) begin
                    state_d = ST_DONE;
                end else begin
                    j_d     = j_q + POST_W'(1);
                    state_d = ST_N_RD;
                end
            end
            ST_DONE: begin
                evt_d   = evt_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered, so they are decoded from the next state;
        // the N_RD read strobe also needs the weight the next cycle will see.
        w_next        = row_d[j_d*SR_SYN_WIDTH +: SR_SYN_WIDTH];
        spike_ready_d = (state_d == ST_IDLE);
        syn_rd_en_d   = (state_d == ST_ROW_RD);
        nr_rd_en_d    = (state_d == ST_N_RD) && !((SKIP_ZERO != 0) && (w_next == '0));
        nr_wr_en_d    = (state_d == ST_N_WR);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            row_q         <= '0;
            j_q           <= '0;
            evt_q         <= '0;
            spike_ready_q <= 1'b1;
            syn_rd_en_q   <= 1'b0;
            nr_rd_en_q    <= 1'b0;
            nr_wr_en_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            j_q           <= j_d;
            evt_q         <= evt_d;
            spike_ready_q <= spike_ready_d;
            syn_rd_en_q   <= syn_rd_en_d;
            nr_rd_en_q    <= nr_rd_en_d;
            nr_wr_en_q    <= nr_wr_en_d;
            done_q        <= done_d;
        end
    end

    neuron_accumulator #(
        .NR_WIDTH    (NR_WIDTH),
        .NR_I_WIDTH  (NR_I_WIDTH),
        .SR_SYN_WIDTH(SR_SYN_WIDTH)
    ) u_acc (
        .state_in (nr_rd_data),
        .weight   (w_cur),
        .state_out(nr_wr_data)
    );

    assign spike_ready = spike_ready_q;
    assign syn_rd_en   = syn_rd_en_q;
    assign syn_rd_addr = idx_q;
    assign nr_rd_en    = nr_rd_en_q;
    assign nr_rd_addr  = j_q;
    assign nr_wr_en    = nr_wr_en_q;
    assign nr_wr_addr  = j_q;
    assign done        = done_q;
    assign event_cnt   = evt_q;

endmodule
